id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode stage sitting on the consumer side of the IF/ID pipeline register.
- Consumes the fetched instruction and PC+4 and decodes RV32I base instructions.
- Reads operands from an internal 32x32 register file, which has a write port driven by writeback.
- Detects load-use hazards, stalling fetch and inserting a bubble; honours branch/jump flush from EX.
- Registers all results into the ID/EX pipeline register that feeds EX.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, register count; x0 hardwired to zero.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr  in  32  instruction from IF/ID.
- PC_n  in  32  PC+4 from IF/ID.
- flush  in  1  branch/jump taken in EX; kill current ID contents.
- wb_en  in  1  writeback enable.
- wb_rd  in  5  writeback register index.
- wb_data  in  32  writeback data.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- ex_pc  out  32  PC of decoded instruction, equal to PC_n-4.
- ex_rs1_val, ex_rs2_val  out  32 each  operand values.
- ex_imm  out  32  sign-extended immediate.
- ex_rs1, ex_rs2, ex_rd  out  5 each  register indices.
- ex_funct3  out  3; ex_funct7b5  out  1.
- ex_ctrl  out  10  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jal, jalr, lui, auipc}.

Behaviour:
- Reset (async): all ex_* outputs 0 (bubble = NOP); all registers x0..x31 = 0; stall = 0.
- Latency: one cycle. Decode is combinational from instr; ex_* update on the rising clk edge.
- Decode by opcode[6:0]:
  - 0110011 R: reg_write.
  - 0010011 I-ALU: reg_write, alu_src.
  - 0000011 LOAD: reg_write, mem_read, mem_to_reg, alu_src.
  - 0100011 STORE: mem_write, alu_src.
  - 1100011 BRANCH: branch.
  - 1101111 JAL: reg_write, jal.
  - 1100111 JALR: reg_write, jalr, alu_src.
  - 0110111 LUI: reg_write, lui.
  - 0010111 AUIPC: reg_write, auipc.
  - Any other opcode: all ctrl 0.
- Immediates per ISA formats I/S/B/U/J, sign-extended from instr[31]. B and J immediates have bit0 = 0; U immediate = instr[31:12]<<12.
- rs1/rs2 "used" flags:
  - rs1 used by R, I-ALU, LOAD, STORE, BRANCH, JALR.
  - rs2 used by R, STORE, BRANCH.
  - Unused index fields are still passed through; hazard logic ignores them.
- Register file:
  - Synchronous write at posedge when wb_en and wb_rd != 0.
  - Writes to x0 are ignored, and x0 always reads 0.
  - Read is combinational with write-through bypass: if wb_en and wb_rd == rs, return wb_data in the same cycle.
- Hazard detection:
  - stall = ex_ctrl.mem_read & (ex_rd != 0) & ((rs1 used & ex_rd == rs1) | (rs2 used & ex_rd == rs2)).
  - When stall is asserted, ID/EX loads a bubble (all ex_* = 0) at the next edge; the upstream holds instr/PC_n, so the instruction is re-decoded next cycle.
- Flush:
  - flush = 1 at an edge loads a bubble into ID/EX.
  - stall is forced 0 while flush = 1, so the wrong-path fetch is not held.
  - Flush has priority over stall.
- Simultaneous writeback and decode of the same register: the bypassed value is captured.
- Reset asserted mid-operation clears the pipeline register and register file immediately, regardless of clk.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - ctrl bit index constants;
  - NOP encoding 0x00000013.
- One sub-module, reg_file: 2 read ports with bypass, 1 write port, async reset.
- Decode, immediate generation, hazard logic and the ID/EX register stay in id_stage.

Test Plan:
- Reset: assert reset for 20 ns mid-run -> all ex_* = 0 and stall = 0 immediately; register reads return 0.
- instr=0x00500093 (addi x1,x0,5) -> next edge:
  - ex_rd = 1, ex_imm = 5, ex_ctrl = reg_write|alu_src;
  - then wb_en = 1, wb_rd = 1, wb_data = 5.
- instr=0xFFF00293 (addi x5,x0,-1) -> ex_imm = 0xFFFFFFFF; PC_n = 0x0000000C gives ex_pc = 0x00000008.
- Load-use sequence:
  - 0x0000A103 (lw x2,0(x1)) followed by 0x001101B3 (add x3,x2,x1) -> stall = 1 for exactly one cycle and a bubble in ID/EX;
  - the add then issues with ex_rs1 = 2, ex_rs2 = 1.
- Flush: flush = 1 while stall conditions hold -> stall = 0 and ID/EX becomes a bubble.
- Bypass / x0:
  - wb_en = 1, wb_rd = 3, wb_data = 0xDEADBEEF in the same cycle as decoding add with rs1 = 3 -> ex_rs1_val = 0xDEADBEEF;
  - wb_rd = 0, wb_data = 7 -> a subsequent read of x0 = 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, control-bit positions and the ID/EX payload.
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int CTRL_W = 10;

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_e;

    // Bit positions inside ex_ctrl, MSB first
    localparam int CTRL_REG_WRITE  = 9;
    localparam int CTRL_MEM_READ   = 8;
    localparam int CTRL_MEM_WRITE  = 7;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_ALU_SRC    = 5;
    localparam int CTRL_BRANCH     = 4;
    localparam int CTRL_JAL        = 3;
    localparam int CTRL_JALR       = 2;
    localparam int CTRL_LUI        = 1;
    localparam int CTRL_AUIPC      = 0;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [2:0]        funct3;
        logic              funct7b5;
        logic [CTRL_W-1:0] ctrl;
    } idex_t;

endpackage

// File: rtl/id_stage_if.sv
// IF/ID inputs, writeback port and ID/EX outputs of the decode stage.
interface id_stage_if;
    import rv_pkg::*;

    logic [XLEN-1:0]   instr;
    logic [XLEN-1:0]   PC_n;
    logic              flush;
    logic              wb_en;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              stall;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_rs1_val;
    logic [XLEN-1:0]   ex_rs2_val;
    logic [XLEN-1:0]   ex_imm;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic [2:0]        ex_funct3;
    logic              ex_funct7b5;
    logic [CTRL_W-1:0] ex_ctrl;

    modport master (
        output instr, PC_n, flush, wb_en, wb_rd, wb_data,
        input  stall, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_funct3, ex_funct7b5, ex_ctrl
    );

    modport slave (
        input  instr, PC_n, flush, wb_en, wb_rd, wb_data,
        output stall, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_funct3, ex_funct7b5, ex_ctrl
    );

endinterface

// File: rtl/id_stage_reg_file.sv
// 32x32 register file: two combinational read ports with write-through bypass, one write port.
module reg_file
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (wb_en && wb_rd != 5'd0) begin
            regs_d[wb_rd] = wb_data;
        end
    end

    // NOTE: the array is reset on purpose; a mid-run reset must leave every register reading zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0)                 ? '0      :
                      (wb_en && wb_rd == rs1_addr)       ? wb_data :
                                                           regs_q[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0)                 ? '0      :
                      (wb_en && wb_rd == rs2_addr)       ? wb_data :
                                                           regs_q[rs2_addr];

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode, immediates, load-use hazard and the ID/EX pipeline register.
module id_stage
    import rv_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    id_stage_if.slave bus
);

    logic [6:0]        opcode;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              rs1_used;
    logic              rs2_used;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic              stall;
    idex_t             idex_d;
    idex_t             idex_q;

    assign opcode = bus.instr[6:0];
    assign rs1    = bus.instr[19:15];
    assign rs2    = bus.instr[24:20];

    reg_file u_reg_file (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .wb_en    (bus.wb_en),
        .wb_rd    (bus.wb_rd),
        .wb_data  (bus.wb_data)
    );

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        ctrl     = '0;
        imm      = '0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl[CTRL_REG_WRITE] = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OP_IMM: begin
                ctrl[CTRL_REG_WRITE] = 1'b1;
                ctrl[CTRL_ALU_SRC]   = 1'b1;
                rs1_used = 1'b1;
                imm      = {{20{bus.instr[31]}}, bus.instr[31:20]};
            end
            OP_LOAD: begin
                ctrl[CTRL_REG_WRITE]  = 1'b1;
                ctrl[CTRL_MEM_READ]   = 1'b1;
                ctrl[CTRL_MEM_TO_REG] = 1'b1;
                ctrl[CTRL_ALU_SRC]    = 1'b1;
                rs1_used = 1'b1;
                imm      = {{20{bus.instr[31]}}, bus.instr[31:20]};
            end
            OP_STORE: begin
                ctrl[CTRL_MEM_WRITE] = 1'b1;
                ctrl[CTRL_ALU_SRC]   = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm      = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
            end
            OP_BRANCH: begin
                ctrl[CTRL_BRANCH] = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm      = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                            bus.instr[30:25], bus.instr[11:8], 1'b0};
            end
            OP_JAL: begin
                ctrl[CTRL_REG_WRITE] = 1'b1;
                ctrl[CTRL_JAL]       = 1'b1;
                imm = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                       bus.instr[20], bus.instr[30:21], 1'b0};
            end
            OP_JALR: begin
                ctrl[CTRL_REG_WRITE] = 1'b1;
                ctrl[CTRL_JALR]      = 1'b1;
                ctrl[CTRL_ALU_SRC]   = 1'b1;
                rs1_used = 1'b1;
                imm      = {{20{bus.instr[31]}}, bus.instr[31:20]};
            end
            OP_LUI: begin
                ctrl[CTRL_REG_WRITE] = 1'b1;
                ctrl[CTRL_LUI]       = 1'b1;
                imm = {bus.instr[31:12], 12'b0};
            end
            OP_AUIPC: begin
                ctrl[CTRL_REG_WRITE] = 1'b1;
                ctrl[CTRL_AUIPC]     = 1'b1;
                imm = {bus.instr[31:12], 12'b0};
            end
            default: ;
        endcase
    end

    // Load-use: the load in EX has not produced data yet; a flush cancels the hold.
    always_comb begin
        stall = 1'b0;
        if (!bus.flush && idex_q.ctrl[CTRL_MEM_READ] && idex_q.rd != 5'd0) begin
            stall = (rs1_used && idex_q.rd == rs1) || (rs2_used && idex_q.rd == rs2);
        end
    end

    always_comb begin
        idex_d = '0;
        if (!bus.flush && !stall) begin
            idex_d.pc       = bus.PC_n - XLEN'(4);
            idex_d.rs1_val  = rs1_val;
            idex_d.rs2_val  = rs2_val;
            idex_d.imm      = imm;
            idex_d.rs1      = rs1;
            idex_d.rs2      = rs2;
            idex_d.rd       = bus.instr[11:7];
            idex_d.funct3   = bus.instr[14:12];
            idex_d.funct7b5 = bus.instr[30];
            idex_d.ctrl     = ctrl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.ex_pc       = idex_q.pc;
    assign bus.ex_rs1_val  = idex_q.rs1_val;
    assign bus.ex_rs2_val  = idex_q.rs2_val;
    assign bus.ex_imm      = idex_q.imm;
    assign bus.ex_rs1      = idex_q.rs1;
    assign bus.ex_rs2      = idex_q.rs2;
    assign bus.ex_rd       = idex_q.rd;
    assign bus.ex_funct3   = idex_q.funct3;
    assign bus.ex_funct7b5 = idex_q.funct7b5;
    assign bus.ex_ctrl     = idex_q.ctrl;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode formats, load-use stall, flush, bypass, x0 and async reset.
module tb_id_stage;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    id_stage_if bus ();

    id_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] I_ADDI_X1_5  = 32'h0050_0093;
    localparam logic [31:0] I_ADDI_X5_M1 = 32'hFFF0_0293;
    localparam logic [31:0] I_LW_X2      = 32'h0000_A103;
    localparam logic [31:0] I_ADD_X3     = 32'h0011_01B3;
    localparam logic [31:0] I_ADD_X4     = 32'h0011_8233;
    localparam logic [31:0] I_ADD_X5_X0  = 32'h0000_02B3;
    localparam logic [31:0] I_SW_X2      = 32'h0020_A023;
    localparam logic [31:0] I_LUI_RS1F2  = 32'h0001_0337;
    localparam logic [31:0] I_SUB        = 32'h4031_00B3;

    function automatic logic [156:0] ex_all();
        return {bus.ex_pc, bus.ex_rs1_val, bus.ex_rs2_val, bus.ex_imm, bus.ex_rs1, bus.ex_rs2,
                bus.ex_rd, bus.ex_funct3, bus.ex_funct7b5, bus.ex_ctrl};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pcn);
        bus.instr = ins;
        bus.PC_n  = pcn;
        step();
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.instr   = NOP;
        bus.PC_n    = 32'd4;
        bus.flush   = 1'b0;
        bus.wb_en   = 1'b0;
        bus.wb_rd   = 5'd0;
        bus.wb_data = '0;
        #12;
        checks++;
        if (ex_all() !== '0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ex=%h stall=%b, want all zero", ex_all(), bus.stall);
        end
        #8 reset = 1'b0;
    endtask

    task automatic test_addi();
        issue(I_ADDI_X1_5, 32'd4);
        checks++;
        if ({bus.ex_rd, bus.ex_imm, bus.ex_ctrl} !== {5'd1, 32'd5, 10'h220}) begin
            errors++;
            $display("FAIL addi: rd=%0d imm=%h ctrl=%h, want 1 00000005 220",
                     bus.ex_rd, bus.ex_imm, bus.ex_ctrl);
        end
        checks++;
        if (bus.ex_pc !== 32'd0) begin
            errors++;
            $display("FAIL addi_pc: got %h want 00000000", bus.ex_pc);
        end
        bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd5;
        step();
        bus.wb_en = 1'b0;
    endtask

    task automatic test_neg_imm();
        issue(I_ADDI_X5_M1, 32'h0000_000C);
        checks++;
        if (bus.ex_imm !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL neg_imm: got %h want ffffffff", bus.ex_imm);
        end
        checks++;
        if (bus.ex_pc !== 32'h0000_0008 || bus.ex_rd !== 5'd5) begin
            errors++;
            $display("FAIL neg_imm_pc_rd: pc=%h rd=%0d, want 00000008 5", bus.ex_pc, bus.ex_rd);
        end
    endtask

    task automatic test_formats();
        logic [31:0] f_ins  [8] = '{32'h0011_2423, 32'hFE20_8EE3, 32'h0010_00EF, 32'h0000_8067,
                                    32'h1234_5337, 32'h8000_0397, 32'h0000_007F, I_ADD_X3};
        logic [31:0] f_imm  [8] = '{32'h0000_0008, 32'hFFFF_FFFC, 32'h0000_0800, 32'h0000_0000,
                                    32'h1234_5000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
        logic [9:0]  f_ctrl [8] = '{10'h0A0, 10'h010, 10'h208, 10'h224,
                                    10'h202, 10'h201, 10'h000, 10'h200};
        for (int i = 0; i < 8; i++) begin
            issue(f_ins[i], 32'h100);
            checks++;
            if (bus.ex_imm !== f_imm[i] || bus.ex_ctrl !== f_ctrl[i]) begin
                errors++;
                $display("FAIL format_%0d (%h): imm=%h ctrl=%h, want %h %h",
                         i, f_ins[i], bus.ex_imm, bus.ex_ctrl, f_imm[i], f_ctrl[i]);
            end
        end
        issue(I_SUB, 32'h104);
        checks++;
        if ({bus.ex_funct7b5, bus.ex_funct3, bus.ex_rs1, bus.ex_rs2, bus.ex_rd}
                !== {1'b1, 3'd0, 5'd2, 5'd3, 5'd1}) begin
            errors++;
            $display("FAIL sub_fields: f7b5=%b f3=%0d rs1=%0d rs2=%0d rd=%0d, want 1 0 2 3 1",
                     bus.ex_funct7b5, bus.ex_funct3, bus.ex_rs1, bus.ex_rs2, bus.ex_rd);
        end
    endtask

    task automatic test_load_use();
        issue(I_LW_X2, 32'h10);
        checks++;
        if ({bus.ex_ctrl, bus.ex_rd, bus.ex_rs1_val} !== {10'h360, 5'd2, 32'd5}) begin
            errors++;
            $display("FAIL lw_decode: ctrl=%h rd=%0d rs1_val=%h, want 360 2 00000005",
                     bus.ex_ctrl, bus.ex_rd, bus.ex_rs1_val);
        end
        bus.instr = I_ADD_X3; bus.PC_n = 32'h14;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: got %b want 1", bus.stall);
        end
        step();
        checks++;
        if (bus.ex_ctrl !== 10'h0 || bus.ex_rd !== 5'd0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL load_use_bubble: ctrl=%h rd=%0d stall=%b, want 000 0 0",
                     bus.ex_ctrl, bus.ex_rd, bus.stall);
        end
        step();
        checks++;
        if ({bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_ctrl, bus.ex_rs2_val, bus.ex_pc}
                !== {5'd2, 5'd1, 5'd3, 10'h200, 32'd5, 32'h10}) begin
            errors++;
            $display("FAIL load_use_reissue: rs1=%0d rs2=%0d rd=%0d ctrl=%h rs2_val=%h pc=%h",
                     bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_ctrl, bus.ex_rs2_val, bus.ex_pc);
        end
        // rs2-only dependency through a store
        issue(I_LW_X2, 32'h20);
        bus.instr = I_SW_X2;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL store_rs2_stall: got %b want 1", bus.stall);
        end
        step();
        step();
        // LUI carries 2 in its rs1 field but does not read it
        issue(I_LW_X2, 32'h30);
        bus.instr = I_LUI_RS1F2;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL unused_rs_no_stall: got %b want 0", bus.stall);
        end
        step();
    endtask

    task automatic test_flush();
        issue(I_LW_X2, 32'h40);
        bus.instr = I_ADD_X3; bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: got %b want 0", bus.stall);
        end
        step();
        bus.flush = 1'b0;
        checks++;
        if (ex_all() !== '0) begin
            errors++;
            $display("FAIL flush_bubble: ex=%h want all zero", ex_all());
        end
    endtask

    task automatic test_bypass();
        bus.instr = I_ADD_X4; bus.PC_n = 32'h50;
        bus.wb_en = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'hDEAD_BEEF;
        step();
        bus.wb_en = 1'b0;
        checks++;
        if (bus.ex_rs1_val !== 32'hDEAD_BEEF || bus.ex_rs2_val !== 32'd5) begin
            errors++;
            $display("FAIL bypass: rs1_val=%h rs2_val=%h, want deadbeef 00000005",
                     bus.ex_rs1_val, bus.ex_rs2_val);
        end
        step();
        checks++;
        if (bus.ex_rs1_val !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bypass_written: got %h want deadbeef", bus.ex_rs1_val);
        end
        bus.instr = I_ADD_X5_X0;
        bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'd7;
        step();
        bus.wb_en = 1'b0;
        checks++;
        if (bus.ex_rs1_val !== 32'd0) begin
            errors++;
            $display("FAIL x0_bypass: got %h want 00000000", bus.ex_rs1_val);
        end
        step();
        checks++;
        if (bus.ex_rs1_val !== 32'd0 || bus.ex_rs2_val !== 32'd0) begin
            errors++;
            $display("FAIL x0_read: rs1_val=%h rs2_val=%h want 0 0", bus.ex_rs1_val, bus.ex_rs2_val);
        end
    endtask

    task automatic test_reset_mid();
        issue(I_LW_X2, 32'h60);
        bus.instr = I_ADD_X3;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_stall: got %b want 1", bus.stall);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (ex_all() !== '0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: ex=%h stall=%b, want all zero", ex_all(), bus.stall);
        end
        #19 reset = 1'b0;
        issue(I_ADD_X4, 32'h70);
        checks++;
        if (bus.ex_rs1_val !== 32'd0 || bus.ex_rs2_val !== 32'd0 || bus.ex_ctrl !== 10'h200) begin
            errors++;
            $display("FAIL reset_regs: rs1_val=%h rs2_val=%h ctrl=%h, want 0 0 200",
                     bus.ex_rs1_val, bus.ex_rs2_val, bus.ex_ctrl);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_neg_imm();
        test_formats();
        test_load_use();
        test_flush();
        test_bypass();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
